// File: rtl/sd_pkg.sv
// ---------------------------------------------------------------------------
// sd_pkg : frame geometry, FSM encoding and the CRC7 step for the SD CMD path
// Rev 1.0 : initial release
// ---------------------------------------------------------------------------
`default_nettype none

package sd_pkg;

  localparam int         SD_FRAME_BITS   = 48;
  localparam int         SD_PAYLOAD_BITS = 40;
  // The frame is payload + CRC + the single end bit
  localparam int         SD_CRC_BITS     = SD_FRAME_BITS - SD_PAYLOAD_BITS - 1;
  localparam logic [6:0] SD_CRC7_POLY    = 7'h09;

  localparam logic [2:0] SD_ST_IDLE  = 3'd0;
  localparam logic [2:0] SD_ST_LOAD  = 3'd1;
  localparam logic [2:0] SD_ST_SHIFT = 3'd2;
  localparam logic [2:0] SD_ST_CRC   = 3'd3;
  localparam logic [2:0] SD_ST_END   = 3'd4;
  localparam logic [2:0] SD_ST_GAP   = 3'd5;

  typedef enum logic [2:0] {
    ST_IDLE  = SD_ST_IDLE,
    ST_LOAD  = SD_ST_LOAD,
    ST_SHIFT = SD_ST_SHIFT,
    ST_CRC   = SD_ST_CRC,
    ST_END   = SD_ST_END,
    ST_GAP   = SD_ST_GAP
  } sd_state_e;

  function automatic logic [6:0] crc7_next(input logic [6:0] crc,
                                           input logic       din,
                                           input logic [6:0] poly);
    logic fb;
    fb = crc[6] ^ din;
    return {crc[5:0], 1'b0} ^ (fb ? poly : 7'h00);
  endfunction

endpackage

`default_nettype wire

// File: rtl/sd_crc7_serial.sv
// ---------------------------------------------------------------------------
// sd_crc7_serial : bit-serial CRC7 accumulator (clear has priority over enable)
// Rev 1.0 : initial release
// ---------------------------------------------------------------------------
`default_nettype none

module sd_crc7_serial
  import sd_pkg::*;
#(
  parameter logic [6:0] POLY = SD_CRC7_POLY
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       clear,
  input  logic       enable,
  input  logic       data_in,
  output logic [6:0] crc
);

  logic [6:0] crc_q;
  logic [6:0] crc_d;

  always_comb begin
    crc_d = crc_q;
    if (clear) begin
      crc_d = 7'h00;
    end else if (enable) begin
      crc_d = crc7_next(crc_q, data_in, POLY);
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      crc_q <= 7'h00;
    end else begin
      crc_q <= crc_d;
    end
  end

  assign crc = crc_q;

endmodule

`default_nettype wire

// File: rtl/sd_cmd_tx.sv
// ---------------------------------------------------------------------------
// sd_cmd_tx : SD CMD-line transmitter, 48-bit frame with on-the-fly CRC7.
// Optional NCC gap after the end bit when SD_CMD_TX_NCC_EN is defined.
// Rev 1.0 : initial release
// ---------------------------------------------------------------------------
`default_nettype none

module sd_cmd_tx
  import sd_pkg::*;
#(
  parameter int         NCC_CYCLES = 8,
  parameter logic [6:0] CRC_POLY   = SD_CRC7_POLY
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        sd_clk_tick,
  input  logic        start,
  input  logic [5:0]  cmd_index,
  input  logic [31:0] argument,
  output logic        sd_cmd_out,
  output logic        sd_cmd_oe,
  output logic        busy,
  output logic        done
);

  sd_state_e                     state_q, state_d;
  logic [SD_PAYLOAD_BITS-1:0]    sr_q, sr_d;
  logic [5:0]                    cnt_q, cnt_d;
  logic                          out_q, out_d;
  logic                          oe_q, oe_d;
  logic                          busy_q, busy_d;
  logic                          done_q, done_d;
  logic                          crc_clear;
  logic                          crc_en;
  logic [2:0]                    crc_sel;
  logic [6:0]                    crc7;

`ifdef SD_CMD_TX_NCC_EN
  localparam int GAP_W = $clog2(NCC_CYCLES + 1);
  logic [GAP_W-1:0]              gap_q, gap_d;
`else
  logic                          unused_ncc;
  assign unused_ncc = ^NCC_CYCLES;
`endif

  sd_crc7_serial #(
    .POLY    (CRC_POLY)
  ) u_crc7 (
    .clk     (clk),
    .reset_n (reset_n),
    .clear   (crc_clear),
    .enable  (crc_en),
    .data_in (sr_q[SD_PAYLOAD_BITS-1]),
    .crc     (crc7)
  );

  always_comb begin
    state_d   = state_q;
    sr_d      = sr_q;
    cnt_d     = cnt_q;
    out_d     = out_q;
    oe_d      = oe_q;
    busy_d    = busy_q;
    done_d    = 1'b0;
    crc_clear = 1'b0;
    crc_en    = 1'b0;
    crc_sel   = cnt_q[2:0] - 3'd1;
`ifdef SD_CMD_TX_NCC_EN
    gap_d     = gap_q;
`endif

    case (state_q)
      ST_IDLE: begin
        if (start) begin
          sr_d      = {2'b01, cmd_index, argument};
          cnt_d     = 6'(SD_PAYLOAD_BITS);
          out_d     = 1'b1;
          oe_d      = 1'b1;
          busy_d    = 1'b1;
          crc_clear = 1'b1;
          state_d   = ST_LOAD;
        end
      end

      // LOAD drives the start bit; both states feed every payload bit to the CRC
      ST_LOAD, ST_SHIFT: begin
        if (sd_clk_tick) begin
          out_d   = sr_q[SD_PAYLOAD_BITS-1];
          sr_d    = {sr_q[SD_PAYLOAD_BITS-2:0], 1'b0};
          crc_en  = 1'b1;
          cnt_d   = cnt_q - 6'd1;
          state_d = ST_SHIFT;
          if (cnt_q == 6'd1) begin
            cnt_d   = 6'(SD_CRC_BITS);
            state_d = ST_CRC;
          end
        end
      end

      ST_CRC: begin
        if (sd_clk_tick) begin
          out_d = crc7[crc_sel];
          cnt_d = cnt_q - 6'd1;
          if (cnt_q == 6'd1) begin
            state_d = ST_END;
          end
        end
      end

`ifdef SD_CMD_TX_NCC_EN
      ST_END: begin
        if (sd_clk_tick) begin
          out_d   = 1'b1;
          gap_d   = GAP_W'(NCC_CYCLES);
          state_d = ST_GAP;
        end
      end

      ST_GAP: begin
        if (sd_clk_tick) begin
          gap_d = gap_q - 1'b1;
          if (gap_q == GAP_W'(1)) begin
            done_d  = 1'b1;
            busy_d  = 1'b0;
            oe_d    = 1'b0;
            state_d = ST_IDLE;
          end
        end
      end
`else
      // cnt_q is 0 on entry; set to 1 once the end bit has been driven
      ST_END: begin
        if (cnt_q != 6'd0) begin
          done_d  = 1'b1;
          busy_d  = 1'b0;
          oe_d    = 1'b0;
          state_d = ST_IDLE;
        end else if (sd_clk_tick) begin
          out_d = 1'b1;
          cnt_d = 6'd1;
        end
      end
`endif

      default: begin
        state_d = ST_IDLE;
        out_d   = 1'b1;
        oe_d    = 1'b0;
        busy_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= ST_IDLE;
      sr_q    <= '0;
      cnt_q   <= 6'd0;
      out_q   <= 1'b1;
      oe_q    <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      sr_q    <= sr_d;
      cnt_q   <= cnt_d;
      out_q   <= out_d;
      oe_q    <= oe_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

`ifdef SD_CMD_TX_NCC_EN
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      gap_q <= '0;
    end else begin
      gap_q <= gap_d;
    end
  end
`endif

  assign sd_cmd_out = out_q;
  assign sd_cmd_oe  = oe_q;
  assign busy       = busy_q;
  assign done       = done_q;

endmodule

`default_nettype wire

// File: tb/tb_sd_cmd_tx.sv
// ---------------------------------------------------------------------------
// tb_sd_cmd_tx : randomized self-checking bench for sd_cmd_tx
// Rev 1.0 : initial release
// ---------------------------------------------------------------------------
`default_nettype none

module tb_sd_cmd_tx;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        sd_clk_tick = 1'b0;
  logic        start = 1'b0;
  logic [5:0]  cmd_index = 6'd0;
  logic [31:0] argument = 32'd0;
  logic        sd_cmd_out;
  logic        sd_cmd_oe;
  logic        busy;
  logic        done;

  int pass_cnt = 0;
  int total_cnt = 0;
  int phase = 0;

  typedef struct {
    logic [47:0] bits;
    logic        accept_ok;
    logic        line_ok;
    logic        stall_ok;
    logic        done_idle_ok;
    logic        done_on_tick;
    logic        timeout;
    int          done_gap;
    int          ticks_at_done;
  } res_t;

  always #5 clk = ~clk;

  sd_cmd_tx dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .sd_clk_tick (sd_clk_tick),
    .start       (start),
    .cmd_index   (cmd_index),
    .argument    (argument),
    .sd_cmd_out  (sd_cmd_out),
    .sd_cmd_oe   (sd_cmd_oe),
    .busy        (busy),
    .done        (done)
  );

  // Reference frame straight from the CRC7 definition: x^7 + x^3 + 1 over the 40 payload bits
  function automatic logic [47:0] ref_frame(input logic [5:0] cmd, input logic [31:0] arg);
    logic [39:0] p;
    logic [6:0]  c;
    logic        fb;
    p = {2'b01, cmd, arg};
    c = 7'h00;
    for (int i = 39; i >= 0; i--) begin
      fb = c[6] ^ p[i];
      c  = {c[5:0], 1'b0} ^ (fb ? 7'h09 : 7'h00);
    end
    return {p, c, 1'b1};
  endfunction

  task automatic next_tick(input int mode, output logic t);
    phase++;
    if (mode == 1) t = ((phase % 4) == 0);
    else if (mode == 2) t = ($urandom_range(0, 2) == 0);
    else t = 1'b0;
  endtask

  task automatic run_frame(input logic [5:0] cmd, input logic [31:0] arg, input int mode,
                           input int dup_at, input int stall_at, output res_t r);
    int   ntk;
    int   it;
    int   end_it;
    int   stall_left;
    logic dup_pending;
    logic stalled;
    logic t;
    logic so, soe, sb;
    int   ndone;
    r.bits = '0; r.line_ok = 1'b1; r.stall_ok = 1'b1; r.done_idle_ok = 1'b0;
    r.done_on_tick = 1'b0; r.timeout = 1'b0; r.done_gap = -1; r.ticks_at_done = -1;
    ntk = 0; it = 0; end_it = -1; ndone = 0;
    stall_left = (stall_at > 0) ? 100 : 0;
    dup_pending = (dup_at > 0);
    so = 1'b0; soe = 1'b0; sb = 1'b0;
    @(negedge clk);
    start = 1'b1; cmd_index = cmd; argument = arg;
    next_tick(mode, t);
    sd_clk_tick = t;
    @(posedge clk); #1;
    r.accept_ok = busy && sd_cmd_oe && sd_cmd_out && !done;
    while (it < 4000 && ndone == 0) begin
      @(negedge clk);
      start = 1'b0;
      cmd_index = 6'($urandom);
      argument = $urandom;
      if (dup_pending && ntk == dup_at) begin
        start = 1'b1;
        cmd_index = cmd ^ 6'h3F;
        dup_pending = 1'b0;
      end
      next_tick(mode, t);
      stalled = 1'b0;
      if (stall_left > 0 && ntk == stall_at) begin
        t = 1'b0;
        stall_left--;
        stalled = 1'b1;
        so = sd_cmd_out; soe = sd_cmd_oe; sb = busy;
      end
      sd_clk_tick = t;
      @(posedge clk); #1;
      if (stalled && (sd_cmd_out !== so || sd_cmd_oe !== soe || busy !== sb || done !== 1'b0))
        r.stall_ok = 1'b0;
      if (t) begin
        ntk++;
        if (ntk <= 48) r.bits[48-ntk] = sd_cmd_out;
        if (ntk == 48) end_it = it;
      end
      if (done) begin
        ndone = 1;
        r.done_gap = it - end_it;
        r.ticks_at_done = ntk;
        r.done_on_tick = t;
        r.done_idle_ok = !busy && !sd_cmd_oe && sd_cmd_out;
      end else begin
        if (ntk >= 1 && (!sd_cmd_oe || !busy)) r.line_ok = 1'b0;
        if (ntk > 48 && !sd_cmd_out) r.line_ok = 1'b0;
      end
      it++;
    end
    if (ndone == 0) r.timeout = 1'b1;
  endtask

  // Expected done timing relative to the tick that drove the end bit
  function automatic logic done_timing_ok(input res_t r);
`ifdef SD_CMD_TX_NCC_EN
    return (r.ticks_at_done == 56) && r.done_on_tick && !r.timeout;
`else
    return (r.done_gap == 1) && !r.timeout;
`endif
  endfunction

  task automatic test_reset;
    reset_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    total_cnt++; if (sd_cmd_out !== 1'b1) $display("FAIL reset_out got %b exp 1", sd_cmd_out); else pass_cnt++;
    total_cnt++; if (sd_cmd_oe !== 1'b0) $display("FAIL reset_oe got %b exp 0", sd_cmd_oe); else pass_cnt++;
    total_cnt++; if (busy !== 1'b0) $display("FAIL reset_busy got %b exp 0", busy); else pass_cnt++;
    total_cnt++; if (done !== 1'b0) $display("FAIL reset_done got %b exp 0", done); else pass_cnt++;
    @(negedge clk);
    reset_n = 1'b1;
  endtask

  task automatic test_cmd0;
    res_t r;
    run_frame(6'd0, 32'd0, 1, 0, 0, r);
    total_cnt++; if (r.accept_ok !== 1'b1) $display("FAIL cmd0_accept got %b exp 1", r.accept_ok); else pass_cnt++;
    total_cnt++; if (r.bits !== 48'h40_0000_0000_95) $display("FAIL cmd0_frame got %h exp %h", r.bits, 48'h40_0000_0000_95); else pass_cnt++;
    total_cnt++; if (r.line_ok !== 1'b1) $display("FAIL cmd0_line got %b exp 1", r.line_ok); else pass_cnt++;
    total_cnt++; if (done_timing_ok(r) !== 1'b1) $display("FAIL cmd0_done_time got gap=%0d ticks=%0d exp end+1clk/56 ticks", r.done_gap, r.ticks_at_done); else pass_cnt++;
    total_cnt++; if (r.done_idle_ok !== 1'b1) $display("FAIL cmd0_done_idle got %b exp 1", r.done_idle_ok); else pass_cnt++;
  endtask

  task automatic test_back_to_back;
    res_t r;
    run_frame(6'd8, 32'h0000_01AA, 1, 0, 0, r);
    total_cnt++; if (r.accept_ok !== 1'b1) $display("FAIL b2b_accept got %b exp 1", r.accept_ok); else pass_cnt++;
    total_cnt++; if (r.bits !== 48'h48_0000_01AA_87) $display("FAIL cmd8_frame got %h exp %h", r.bits, 48'h48_0000_01AA_87); else pass_cnt++;
    total_cnt++; if (done_timing_ok(r) !== 1'b1) $display("FAIL cmd8_done_time got gap=%0d ticks=%0d", r.done_gap, r.ticks_at_done); else pass_cnt++;
  endtask

  task automatic test_cmd17_55;
    res_t r;
    run_frame(6'd17, 32'd0, 2, 0, 0, r);
    total_cnt++; if (r.bits[7:0] !== 8'h55) $display("FAIL cmd17_crc_byte got %h exp 55", r.bits[7:0]); else pass_cnt++;
    total_cnt++; if (r.line_ok !== 1'b1) $display("FAIL cmd17_line got %b exp 1", r.line_ok); else pass_cnt++;
    run_frame(6'd55, 32'd0, 2, 0, 0, r);
    total_cnt++; if (r.bits[7:0] !== 8'h65) $display("FAIL cmd55_crc_byte got %h exp 65", r.bits[7:0]); else pass_cnt++;
    total_cnt++; if (done_timing_ok(r) !== 1'b1) $display("FAIL cmd55_done_time got gap=%0d ticks=%0d", r.done_gap, r.ticks_at_done); else pass_cnt++;
  endtask

  task automatic test_random;
    res_t        r;
    logic [5:0]  c;
    logic [31:0] a;
    logic [47:0] exp_f;
    for (int n = 0; n < 8; n++) begin
      c = 6'($urandom);
      a = $urandom;
      exp_f = ref_frame(c, a);
      run_frame(c, a, (n % 2) + 1, 0, 0, r);
      total_cnt++; if (r.bits !== exp_f) $display("FAIL rand_frame%0d got %h exp %h", n, r.bits, exp_f); else pass_cnt++;
      total_cnt++; if ((r.line_ok && done_timing_ok(r) && r.done_idle_ok) !== 1'b1)
        $display("FAIL rand_ctrl%0d got line=%b gap=%0d ticks=%0d idle=%b exp all ok", n, r.line_ok, r.done_gap, r.ticks_at_done, r.done_idle_ok);
      else pass_cnt++;
    end
  endtask

  task automatic test_mid_start;
    res_t r;
    int   extra_done;
    logic extra_busy;
    logic t;
    run_frame(6'd17, 32'hDEAD_BEEF, 2, 10, 0, r);
    total_cnt++; if (r.bits !== ref_frame(6'd17, 32'hDEAD_BEEF)) $display("FAIL midstart_frame got %h exp %h", r.bits, ref_frame(6'd17, 32'hDEAD_BEEF)); else pass_cnt++;
    extra_done = 0;
    extra_busy = 1'b0;
    for (int i = 0; i < 120; i++) begin
      @(negedge clk);
      next_tick(1, t);
      sd_clk_tick = t;
      @(posedge clk); #1;
      if (done) extra_done++;
      if (busy || sd_cmd_oe) extra_busy = 1'b1;
    end
    total_cnt++; if (extra_done !== 0) $display("FAIL midstart_done_count got %0d extra exp 0", extra_done); else pass_cnt++;
    total_cnt++; if (extra_busy !== 1'b0) $display("FAIL midstart_idle got busy/oe=%b exp 0", extra_busy); else pass_cnt++;
  endtask

  task automatic test_stall;
    res_t r;
    run_frame(6'd41, 32'h4030_0000, 1, 0, 15, r);
    total_cnt++; if (r.stall_ok !== 1'b1) $display("FAIL stall_frozen got %b exp 1", r.stall_ok); else pass_cnt++;
    total_cnt++; if (r.bits !== ref_frame(6'd41, 32'h4030_0000)) $display("FAIL stall_frame got %h exp %h", r.bits, ref_frame(6'd41, 32'h4030_0000)); else pass_cnt++;
  endtask

  task automatic test_reset_mid;
    res_t r;
    int   ntk;
    int   guard;
    int   seen_done;
    logic t;
    @(negedge clk);
    start = 1'b1; cmd_index = 6'd2; argument = 32'h1234_5678;
    sd_clk_tick = 1'b0;
    @(posedge clk); #1;
    ntk = 0;
    guard = 0;
    while (ntk < 20 && guard < 500) begin
      @(negedge clk);
      start = 1'b0;
      next_tick(1, t);
      sd_clk_tick = t;
      @(posedge clk); #1;
      if (t) ntk++;
      guard++;
    end
    total_cnt++; if (ntk !== 20) $display("FAIL rstmid_reach got %0d ticks exp 20", ntk); else pass_cnt++;
    @(negedge clk);
    sd_clk_tick = 1'b0;
    reset_n = 1'b0;
    #1;
    total_cnt++; if ({sd_cmd_oe, sd_cmd_out, busy, done} !== 4'b0100)
      $display("FAIL rstmid_outputs got oe,out,busy,done=%b exp 0100", {sd_cmd_oe, sd_cmd_out, busy, done});
    else pass_cnt++;
    @(negedge clk);
    reset_n = 1'b1;
    seen_done = 0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      next_tick(1, t);
      sd_clk_tick = t;
      @(posedge clk); #1;
      if (done || sd_cmd_oe) seen_done++;
    end
    total_cnt++; if (seen_done !== 0) $display("FAIL rstmid_no_done got %0d active cycles exp 0", seen_done); else pass_cnt++;
    run_frame(6'd55, 32'd0, 1, 0, 0, r);
    total_cnt++; if (r.bits !== 48'h77_0000_0000_65) $display("FAIL rstmid_next_frame got %h exp %h", r.bits, 48'h77_0000_0000_65); else pass_cnt++;
  endtask

  initial begin
    test_reset;
    test_cmd0;
    test_back_to_back;
    test_cmd17_55;
    test_random;
    test_mid_start;
    test_stall;
    test_reset_mid;
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule

`default_nettype wire
